video_timing_probe: RTL and testbench

Measures and tracks a raster stream produced by the core's video timing generator: pixel-enable, blanking and sync strobes in; measured geometry, current active-area coordinates and a lock indication out. It sits beside the arcade video path, on the same clock as the timing generator. Downstream capture and overlay logic use it to address pixels and to qualify a stable mode before use.

---
 rtl/video_timing_probe_if.sv | 32 +++
 rtl/video_timing_probe.sv | 201 ++++++++++++++++++++
 tb/tb_video_timing_probe.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/video_timing_probe_if.sv
// rtl/video_timing_probe_if.sv - raster strobes in, measured geometry and coordinates out
interface video_timing_probe_if #(
  parameter int CW = 10
);
  logic          CE;
  logic          HBLK;
  logic          VBLK;
  logic          HSYN;
  logic          VSYN;
  logic [8:0]    XPOS;
  logic [8:0]    YPOS;
  logic          ACTIVE;
  logic          SOF;
  logic [CW-1:0] HTOT;
  logic [8:0]    HACT;
  logic [7:0]    HSW;
  logic [CW-1:0] VTOT;
  logic [8:0]    VACT;
  logic [3:0]    VSW;
  logic          LOCKED;
  logic          OVF;

  modport master (
    output CE, HBLK, VBLK, HSYN, VSYN,
    input  XPOS, YPOS, ACTIVE, SOF, HTOT, HACT, HSW, VTOT, VACT, VSW, LOCKED, OVF
  );

  modport slave (
    input  CE, HBLK, VBLK, HSYN, VSYN,
    output XPOS, YPOS, ACTIVE, SOF, HTOT, HACT, HSW, VTOT, VACT, VSW, LOCKED, OVF
  );
endinterface

// File: rtl/video_timing_probe.sv
// rtl/video_timing_probe.sv - measures raster geometry, tracks active coordinates, qualifies a stable mode
module video_timing_probe #(
  parameter int CW       = 10,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                 MCLK,
  input  logic                 RESET,
  video_timing_probe_if.slave  vid
);

  localparam logic [CW-1:0] TMAX = {CW{1'b1}};

  typedef enum logic [1:0] {
    S_UNLOCKED  = 2'd0,
    S_CANDIDATE = 2'd1,
    S_LOCKED    = 2'd2
  } lock_state_t;

  lock_state_t state_q, state_d;

  logic          hblk_q, vblk_ls_q, vs_line_q;
  logic [CW-1:0] hcnt_q, lcnt_q, ref_htot_q;
  logic [8:0]    acnt_q, vacnt_q;
  logic [7:0]    scnt_q;
  logic [3:0]    vscnt_q;
  logic          ref_valid_q, first_pend_q, incons_q;
  logic [CW-1:0] prev_htot_q, prev_vtot_q;
  logic [8:0]    prev_hact_q, prev_vact_q;
  logic          prev_valid_q;

  logic [8:0]    xpos_q, ypos_q;
  logic          active_q, sof_q, locked_q, ovf_q;
  logic [CW-1:0] htot_q, vtot_q;
  logic [8:0]    hact_q, vact_q;
  logic [7:0]    hsw_q;
  logic [3:0]    vsw_q;

  logic       hs_n, vs_n, line_start, frame_start;
  logic       hcnt_max, acnt_max, scnt_max, lcnt_max, vacnt_max, vscnt_max;
  logic       sat_evt, frame_good, geom_match;
  logic [3:0] vsw_new;

  always_comb begin
    hs_n        = SYNC_POL ? vid.HSYN : ~vid.HSYN;
    vs_n        = SYNC_POL ? vid.VSYN : ~vid.VSYN;
    line_start  = hblk_q & ~vid.HBLK;
    frame_start = line_start & ~vid.VBLK & vblk_ls_q;

    hcnt_max  = (hcnt_q == TMAX);
    acnt_max  = (acnt_q == 9'd511);
    scnt_max  = (scnt_q == 8'd255);
    lcnt_max  = (lcnt_q == TMAX);
    vacnt_max = (vacnt_q == 9'd511);
    vscnt_max = (vscnt_q == 4'd15);

    // A saturation event is an increment attempted on a counter already at its ceiling.
    sat_evt = (~line_start & (hcnt_max | (~vid.HBLK & acnt_max) | (hs_n & scnt_max)))
            | (line_start & ~frame_start & (lcnt_max | (~vid.VBLK & vacnt_max)))
            | (line_start & vs_line_q & vscnt_max);

    vsw_new = (vs_line_q && !vscnt_max) ? vscnt_q + 4'd1 : vscnt_q;

    // The line ending at frame start is the last of the old frame and must match its first line too.
    frame_good = ref_valid_q & ~first_pend_q & ~incons_q & (hcnt_q == ref_htot_q) & ~sat_evt;
    geom_match = prev_valid_q
               & (hcnt_q == prev_htot_q) & (acnt_q == prev_hact_q)
               & (lcnt_q == prev_vtot_q) & (vacnt_q == prev_vact_q);
  end

  always_comb begin
    state_d = state_q;
    if (vid.CE) begin
      if (sat_evt && state_q != S_UNLOCKED) begin
        state_d = S_CANDIDATE;
      end else if (frame_start) begin
        case (state_q)
          S_UNLOCKED:  state_d = S_CANDIDATE;
          S_CANDIDATE: if (frame_good && geom_match) state_d = S_LOCKED;
          default:     if (!(frame_good && geom_match)) state_d = S_CANDIDATE;
        endcase
      end
    end
  end

  always_ff @(posedge MCLK) begin
    if (RESET) state_q <= S_UNLOCKED;
    else       state_q <= state_d;
  end

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      hblk_q       <= 1'b0;
      vblk_ls_q    <= 1'b0;
      vs_line_q    <= 1'b0;
      hcnt_q       <= '0;
      lcnt_q       <= '0;
      ref_htot_q   <= '0;
      acnt_q       <= '0;
      vacnt_q      <= '0;
      scnt_q       <= '0;
      vscnt_q      <= '0;
      ref_valid_q  <= 1'b0;
      first_pend_q <= 1'b0;
      incons_q     <= 1'b0;
      prev_htot_q  <= '0;
      prev_vtot_q  <= '0;
      prev_hact_q  <= '0;
      prev_vact_q  <= '0;
      prev_valid_q <= 1'b0;
      xpos_q       <= '0;
      ypos_q       <= '0;
      active_q     <= 1'b0;
      sof_q        <= 1'b0;
      locked_q     <= 1'b0;
      ovf_q        <= 1'b0;
      htot_q       <= '0;
      vtot_q       <= '0;
      hact_q       <= '0;
      vact_q       <= '0;
      hsw_q        <= '0;
      vsw_q        <= '0;
    end else begin
      sof_q    <= 1'b0;
      locked_q <= (state_d == S_LOCKED);
      if (vid.CE) begin
        hblk_q   <= vid.HBLK;
        active_q <= ~vid.HBLK & ~vid.VBLK;
        sof_q    <= frame_start;
        if (sat_evt) ovf_q <= 1'b1;

        if (line_start) begin
          hcnt_q    <= CW'(1);
          acnt_q    <= 9'd1;
          scnt_q    <= {7'd0, hs_n};
          vs_line_q <= vs_n;
          vblk_ls_q <= vid.VBLK;
          if (frame_start) begin
            htot_q       <= hcnt_q;
            hact_q       <= acnt_q;
            hsw_q        <= scnt_q;
            vtot_q       <= lcnt_q;
            vact_q       <= vacnt_q;
            vsw_q        <= vsw_new;
            lcnt_q       <= CW'(1);
            vacnt_q      <= 9'd1;
            vscnt_q      <= 4'd0;
            prev_htot_q  <= hcnt_q;
            prev_hact_q  <= acnt_q;
            prev_vtot_q  <= lcnt_q;
            prev_vact_q  <= vacnt_q;
            prev_valid_q <= frame_good;
            first_pend_q <= 1'b1;
            incons_q     <= 1'b0;
          end else begin
            lcnt_q  <= lcnt_max ? lcnt_q : lcnt_q + CW'(1);
            vacnt_q <= (vid.VBLK || vacnt_max) ? vacnt_q : vacnt_q + 9'd1;
            vscnt_q <= vsw_new;
            // The first line of each frame becomes the reference total for the rest of it.
            if (first_pend_q) begin
              ref_htot_q   <= hcnt_q;
              ref_valid_q  <= 1'b1;
              first_pend_q <= 1'b0;
            end else if (ref_valid_q && hcnt_q != ref_htot_q) begin
              incons_q <= 1'b1;
            end
          end
        end else begin
          hcnt_q    <= hcnt_max ? hcnt_q : hcnt_q + CW'(1);
          acnt_q    <= (vid.HBLK || acnt_max) ? acnt_q : acnt_q + 9'd1;
          scnt_q    <= (!hs_n || scnt_max) ? scnt_q : scnt_q + 8'd1;
          vs_line_q <= vs_line_q | vs_n;
        end

        if (!vid.HBLK) begin
          if (line_start)              xpos_q <= 9'd0;
          else if (xpos_q != 9'd511)   xpos_q <= xpos_q + 9'd1;
        end
        if (line_start && !vid.VBLK) begin
          if (frame_start)             ypos_q <= 9'd0;
          else if (ypos_q != 9'd511)   ypos_q <= ypos_q + 9'd1;
        end

        if (sat_evt) prev_valid_q <= 1'b0;
      end
    end
  end

  assign vid.XPOS   = xpos_q;
  assign vid.YPOS   = ypos_q;
  assign vid.ACTIVE = active_q;
  assign vid.SOF    = sof_q;
  assign vid.HTOT   = htot_q;
  assign vid.HACT   = hact_q;
  assign vid.HSW    = hsw_q;
  assign vid.VTOT   = vtot_q;
  assign vid.VACT   = vact_q;
  assign vid.VSW    = vsw_q;
  assign vid.LOCKED = locked_q;
  assign vid.OVF    = ovf_q;

endmodule

// File: tb/tb_video_timing_probe.sv
// tb/tb_video_timing_probe.sv - directed raster bench for video_timing_probe on a reduced geometry
module tb_video_timing_probe;

  localparam int HT  = 40;
  localparam int HA  = 30;
  localparam int HS0 = 32;
  localparam int HS1 = 35;
  localparam int VT  = 24;
  localparam int VA  = 20;
  localparam int VS0 = 20;
  localparam int VS1 = 22;
  localparam int NONE = -1;

  logic MCLK = 1'b0;
  logic RESET;

  video_timing_probe_if #(.CW(10)) vid ();

  video_timing_probe #(.CW(10), .SYNC_POL(1'b0)) dut (
    .MCLK  (MCLK),
    .RESET (RESET),
    .vid   (vid)
  );

  always #5 MCLK = ~MCLK;

  int checks = 0;
  int passed = 0;
  int sof_n  = 0;
  logic [8:0] obs_x, obs_y;
  logic       obs_active, obs_sof;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One CE tick followed by one idle MCLK; syncs are active low on the wire.
  task automatic tick(input logic h, input logic v, input logic hs, input logic vs);
    vid.CE = 1'b1; vid.HBLK = h; vid.VBLK = v; vid.HSYN = ~hs; vid.VSYN = ~vs;
    @(posedge MCLK); #1;
    vid.CE = 1'b0;
    obs_x = vid.XPOS; obs_y = vid.YPOS; obs_active = vid.ACTIVE; obs_sof = vid.SOF;
    if (vid.SOF === 1'b1) sof_n++;
    @(posedge MCLK); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_xpos"},   vid.XPOS,   0);
    check({tag, "_ypos"},   vid.YPOS,   0);
    check({tag, "_active"}, vid.ACTIVE, 0);
    check({tag, "_sof"},    vid.SOF,    0);
    check({tag, "_htot"},   vid.HTOT,   0);
    check({tag, "_vtot"},   vid.VTOT,   0);
    check({tag, "_locked"}, vid.LOCKED, 0);
    check({tag, "_ovf"},    vid.OVF,    0);
  endtask

  task automatic run_line(input int l, input int ht, input bit chk, input bit stall, input bit rst);
    logic v, vs;
    v  = (l >= VA);
    vs = (l >= VS0 && l <= VS1);
    for (int t = 0; t < ht; t++) begin
      tick(t >= HA, v, (t >= HS0 && t <= HS1), vs);
      if (chk && l == 0 && t == 0) begin
        check("first_xpos",   obs_x,      0);
        check("first_ypos",   obs_y,      0);
        check("first_active", obs_active, 1);
        check("first_sof",    obs_sof,    1);
        check("sof_width",    vid.SOF,    0);
      end
      if (chk && l == VA-1 && t == HA-1) begin
        check("last_xpos",   obs_x,      HA-1);
        check("last_ypos",   obs_y,      VA-1);
        check("last_active", obs_active, 1);
      end
      if (stall && t == 10) begin
        repeat (50) @(posedge MCLK);
        #1;
        check("stall_xpos",   vid.XPOS,   10);
        check("stall_active", vid.ACTIVE, 1);
        check("stall_sof",    vid.SOF,    0);
      end
      if (rst && t == 5) begin
        RESET = 1'b1;
        @(posedge MCLK); #1;
        RESET = 1'b0;
        check_all_zero("midreset");
      end
    end
  endtask

  task automatic run_frame(input int ht_a, input int ht_b, input int sw, input int long_l,
                           input bit chk, input int stall_l, input int rst_l);
    int ht;
    for (int l = 0; l < VT; l++) begin
      ht = (l < sw) ? ht_a : ht_b;
      if (l == long_l) ht = HA + 1100;
      run_line(l, ht, chk, l == stall_l, l == rst_l);
    end
  endtask

  initial begin
    RESET = 1'b1;
    vid.CE = 1'b0; vid.HBLK = 1'b1; vid.VBLK = 1'b1; vid.HSYN = 1'b1; vid.VSYN = 1'b1;
    repeat (3) @(posedge MCLK);
    #1;
    check_all_zero("reset");
    RESET = 1'b0;
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);

    // Nominal stream: frames 0..3, coordinates checked in frame 2.
    run_frame(HT, HT, VT, NONE, 1'b0, NONE, NONE);
    check("nolock_before_sof", vid.HTOT, 0);
    run_frame(HT, HT, VT, NONE, 1'b0, NONE, NONE);
    run_frame(HT, HT, VT, NONE, 1'b1, NONE, NONE);
    run_frame(HT, HT, VT, NONE, 1'b0, NONE, NONE);
    check("sof_count", sof_n,      3);
    check("nom_htot",  vid.HTOT,   40);
    check("nom_hact",  vid.HACT,   30);
    check("nom_hsw",   vid.HSW,    4);
    check("nom_vtot",  vid.VTOT,   24);
    check("nom_vact",  vid.VACT,   20);
    check("nom_vsw",   vid.VSW,    3);
    check("nom_lock",  vid.LOCKED, 1);
    check("nom_ovf",   vid.OVF,    0);

    // Mode change to 39-tick lines at line 12.
    run_frame(HT, HT-1, 12, NONE, 1'b0, NONE, NONE);
    check("mc_lock_held", vid.LOCKED, 1);
    run_frame(HT-1, HT-1, VT, NONE, 1'b0, NONE, NONE);
    check("mc_lock_drop", vid.LOCKED, 0);
    check("mc_htot",      vid.HTOT,   39);
    check("mc_sof_count", sof_n,      5);
    run_frame(HT-1, HT-1, VT, NONE, 1'b0, NONE, NONE);
    check("mc_cand",      vid.LOCKED, 0);
    run_frame(HT-1, HT-1, VT, NONE, 1'b0, NONE, NONE);
    check("mc_relock",    vid.LOCKED, 1);
    check("mc_htot2",     vid.HTOT,   39);

    // CE stall inside active video.
    run_frame(HT-1, HT-1, VT, NONE, 1'b0, 5, NONE);
    run_frame(HT-1, HT-1, VT, NONE, 1'b0, NONE, NONE);
    check("stall_htot", vid.HTOT,   39);
    check("stall_hact", vid.HACT,   30);
    check("stall_vtot", vid.VTOT,   24);
    check("stall_lock", vid.LOCKED, 1);

    // Reset at line 10; measurement resumes from line 11.
    run_frame(HT-1, HT-1, VT, NONE, 1'b0, NONE, 10);
    run_frame(HT-1, HT-1, VT, NONE, 1'b0, NONE, NONE);
    check("rst_lock1", vid.LOCKED, 0);
    check("rst_vtot1", vid.VTOT,   13);
    check("rst_htot1", vid.HTOT,   39);
    run_frame(HT-1, HT-1, VT, NONE, 1'b0, NONE, NONE);
    check("rst_lock2", vid.LOCKED, 0);
    check("rst_vtot2", vid.VTOT,   24);
    run_frame(HT-1, HT-1, VT, NONE, 1'b0, NONE, NONE);
    check("rst_lock3", vid.LOCKED, 1);

    // Saturation: 1100 extra blank ticks on line 8.
    run_frame(HT-1, HT-1, VT, 8, 1'b0, NONE, NONE);
    check("sat_ovf",  vid.OVF,    1);
    check("sat_lock", vid.LOCKED, 0);
    run_frame(HT-1, HT-1, VT, NONE, 1'b0, NONE, NONE);
    run_frame(HT-1, HT-1, VT, NONE, 1'b0, NONE, NONE);
    check("sat_ovf_sticky", vid.OVF, 1);
    RESET = 1'b1;
    @(posedge MCLK); #1;
    RESET = 1'b0;
    check("sat_ovf_cleared", vid.OVF,    0);
    check("sat_lock_reset",  vid.LOCKED, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
